fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the fetch stage and the control unit:
// datapath width, major opcodes and the canonical NOP encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a flush input. The read data is the head entry
// and stays stable until it is popped.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  // overflow/underflow guards
  always_comb begin
    push_s = push && (count_r != (AW+1)'(DEPTH));
    pop_s  = pop && (count_r != {(AW+1){1'b0}});
  end

  // entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // pointers and occupancy; flush empties the queue without touching storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word requests to instruction
// memory, in-order response buffering, decode handshake and branch redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   pc_r;
  logic [CW-1:0]     drop_cnt_r;
  logic              run_r;
  logic [XLEN-1:0]   hold_instr_r;
  logic [XLEN-1:0]   hold_pc_r;

  logic [CW-1:0]     pcq_count_s;
  logic [CW-1:0]     buf_count_s;
  logic [XLEN-1:0]   pcq_rdata_s;
  logic [2*XLEN-1:0] buf_rdata_s;
  logic [XLEN-1:0]   target_s;
  logic              req_valid_s;
  logic              issue_s;
  logic              buf_push_s;
  logic              id_valid_s;
  logic              id_pop_s;
  logic [XLEN-1:0]   head_instr_s;
  logic [XLEN-1:0]   head_pc_s;

  // Credits cover in-flight requests plus buffered instructions, so a
  // response always has a free buffer slot. The in-flight PC queue occupancy
  // is the outstanding-request count.
  always_comb begin
    target_s    = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
    req_valid_s = run_r && ((pcq_count_s + buf_count_s) < CW'(DEPTH))
                  && !redirect_valid && (drop_cnt_r == {CW{1'b0}});
    issue_s     = req_valid_s && imem_req_ready;
    buf_push_s  = imem_rsp_valid && !redirect_valid && (drop_cnt_r == {CW{1'b0}});
    id_valid_s  = (buf_count_s != {CW{1'b0}});
    id_pop_s    = id_valid_s && id_ready;
  end

  // decode sees the buffer head, or the last presented values when empty
  always_comb begin
    head_instr_s = hold_instr_r;
    head_pc_s    = hold_pc_r;
    if (id_valid_s) begin
      head_instr_s = buf_rdata_s[2*XLEN-1:XLEN];
      head_pc_s    = buf_rdata_s[XLEN-1:0];
    end else begin
      head_instr_s = hold_instr_r;
      head_pc_s    = hold_pc_r;
    end
  end

  // PC, redirect drop accounting and request enable after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      drop_cnt_r <= {CW{1'b0}};
      run_r      <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (redirect_valid) begin
        pc_r       <= target_s;
        drop_cnt_r <= pcq_count_s - CW'(imem_rsp_valid);
      end else begin
        if (issue_s) begin
          pc_r <= pc_r + XLEN'(4);
        end
        if (imem_rsp_valid && (drop_cnt_r != {CW{1'b0}})) begin
          drop_cnt_r <= drop_cnt_r - CW'(1);
        end
      end
    end
  end

  // last presented decode values, held while the buffer is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr_r <= {XLEN{1'b0}};
      hold_pc_r    <= {XLEN{1'b0}};
    end else begin
      hold_instr_r <= head_instr_s;
      hold_pc_r    <= head_pc_s;
    end
  end

  // PCs of requests still in flight; one retires per response, kept or dropped
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (issue_s),
    .wdata (pc_r),
    .pop   (imem_rsp_valid),
    .rdata (pcq_rdata_s),
    .count (pcq_count_s)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (buf_push_s),
    .wdata ({imem_rsp_data, pcq_rdata_s}),
    .pop   (id_pop_s),
    .rdata (buf_rdata_s),
    .count (buf_count_s)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign id_valid       = id_valid_s;
  assign id_instr       = head_instr_s;
  assign id_pc          = head_pc_s;
  assign id_opcode      = opcode_of(head_instr_s);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, wrap and mid-burst reset
// sequences, then random traffic against a queue-based reference model.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: fetch PC, in-flight requests (with discard marks),
  // buffered instructions, last values shown to decode
  logic [31:0] m_pc;
  bit          m_run;
  logic [31:0] infl_pc[$];
  bit          infl_drop[$];
  logic [31:0] bq_instr[$];
  logic [31:0] bq_pc[$];
  logic [31:0] m_last_instr, m_last_pc;
  // memory environment and observation
  logic [31:0] mem_q[$];
  logic [31:0] issued[$];
  bit          s_rv, s_iv;
  logic [31:0] s_addr, s_pc;
  logic [6:0]  s_op;

  typedef struct {
    bit          idr, rdy, go, redir;
    logic [31:0] rpc;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[25];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0063;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_rv(input bit redir);
    int nd = 0;
    foreach (infl_drop[i]) if (infl_drop[i]) nd++;
    return m_run && (infl_pc.size() + bq_pc.size() < DEPTH) && !redir && (nd == 0);
  endfunction

  task automatic model_reset();
    infl_pc.delete(); infl_drop.delete(); bq_instr.delete(); bq_pc.delete();
    mem_q.delete(); issued.delete();
    m_pc = 32'h0; m_run = 1'b0; m_last_instr = 32'h0; m_last_pc = 32'h0;
  endtask

  task automatic step(input bit idr, input bit rdy, input bit go, input bit redir,
                      input logic [31:0] rpc);
    bit rsp, e_rv, e_iv;
    logic [31:0] e_instr, e_pc;
    @(negedge clk);
    rsp = go && (mem_q.size() > 0);
    imem_req_ready = rdy; id_ready = idr; redirect_valid = redir; redirect_pc = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_q[0]) : 32'h0;
    #1;
    e_rv    = model_rv(redir);
    e_iv    = bq_pc.size() > 0;
    e_instr = e_iv ? bq_instr[0] : m_last_instr;
    e_pc    = e_iv ? bq_pc[0] : m_last_pc;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, e_rv});
    chk("req_addr", imem_req_addr, m_pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, e_iv});
    chk("id_instr", id_instr, e_instr);
    chk("id_pc", id_pc, e_pc);
    chk("id_opcode", {25'b0, id_opcode}, {25'b0, e_instr[6:0]});
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = id_valid; s_pc = id_pc; s_op = id_opcode;
    // memory environment reacts to what the DUT actually did
    if (rsp) void'(mem_q.pop_front());
    if (imem_req_valid && rdy) begin
      mem_q.push_back(imem_req_addr);
      issued.push_back(imem_req_addr);
    end
    // model state update for the coming edge
    if (e_iv) begin m_last_instr = e_instr; m_last_pc = e_pc; end
    if (e_iv && idr) begin void'(bq_instr.pop_front()); void'(bq_pc.pop_front()); end
    if (rsp && infl_pc.size() > 0) begin
      if (!infl_drop[0] && !redir) begin
        bq_instr.push_back(imem_rsp_data);
        bq_pc.push_back(infl_pc[0]);
      end
      void'(infl_pc.pop_front()); void'(infl_drop.pop_front());
    end
    if (redir) begin
      bq_instr.delete(); bq_pc.delete();
      foreach (infl_drop[i]) infl_drop[i] = 1'b1;
      m_pc = rpc & 32'hFFFF_FFFC;
    end else if (e_rv && rdy) begin
      infl_pc.push_back(m_pc); infl_drop.push_back(1'b0);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'h0);
    chk({tag, "_id_instr"}, id_instr, 32'h0);
    chk({tag, "_id_pc"}, id_pc, 32'h0);
  endtask

  initial begin
    bit seen, prev_redir, rd, rdy, idr, go;
    // idr rdy go redir rpc | req_valid addr id_valid id_pc
    tbl[0]  = '{0,1,1,0,32'h0,   1,32'h0,  0,32'h0};
    tbl[1]  = '{0,1,1,0,32'h0,   1,32'h4,  0,32'h0};
    tbl[2]  = '{0,1,1,0,32'h0,   0,32'h8,  1,32'h0};
    tbl[3]  = '{0,1,1,0,32'h0,   0,32'h8,  1,32'h0};
    tbl[4]  = '{0,1,1,0,32'h0,   0,32'h8,  1,32'h0};
    tbl[5]  = '{1,1,1,0,32'h0,   0,32'h8,  1,32'h0};
    tbl[6]  = '{1,1,1,0,32'h0,   1,32'h8,  1,32'h4};
    tbl[7]  = '{0,1,1,0,32'h0,   1,32'hC,  0,32'h4};
    tbl[8]  = '{0,1,1,0,32'h0,   0,32'h10, 1,32'h8};
    tbl[9]  = '{1,1,1,0,32'h0,   0,32'h10, 1,32'h8};
    tbl[10] = '{1,1,1,0,32'h0,   1,32'h10, 1,32'hC};
    tbl[11] = '{1,1,0,0,32'h0,   1,32'h14, 0,32'hC};
    tbl[12] = '{1,1,0,1,32'h100, 0,32'h18, 0,32'hC};
    tbl[13] = '{1,1,1,0,32'h0,   0,32'h100,0,32'hC};
    tbl[14] = '{1,1,1,0,32'h0,   0,32'h100,0,32'hC};
    tbl[15] = '{1,1,1,0,32'h0,   1,32'h100,0,32'hC};
    tbl[16] = '{1,1,1,0,32'h0,   1,32'h104,0,32'hC};
    tbl[17] = '{1,1,0,0,32'h0,   0,32'h108,1,32'h100};
    tbl[18] = '{1,1,0,0,32'h0,   1,32'h108,0,32'h100};
    tbl[19] = '{1,1,1,1,32'h203, 0,32'h10C,0,32'h100};
    tbl[20] = '{1,1,1,0,32'h0,   0,32'h200,0,32'h100};
    tbl[21] = '{1,1,1,0,32'h0,   1,32'h200,0,32'h100};
    tbl[22] = '{1,1,1,0,32'h0,   1,32'h204,0,32'h100};
    tbl[23] = '{1,1,1,0,32'h0,   0,32'h208,1,32'h200};
    tbl[24] = '{1,1,1,0,32'h0,   1,32'h208,1,32'h204};

    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1; m_run = 1'b1;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].idr, tbl[i].rdy, tbl[i].go, tbl[i].redir, tbl[i].rpc);
      chk($sformatf("tbl%0d_req_valid", i), {31'b0, s_rv}, {31'b0, tbl[i].e_rv});
      chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_id_valid", i), {31'b0, s_iv}, {31'b0, tbl[i].e_iv});
      chk($sformatf("tbl%0d_id_pc", i), s_pc, tbl[i].e_pc);
    end

    // PC wrap at the top of the address space
    step(1, 1, 1, 1, 32'hFFFF_FFFF);
    issued.delete();
    repeat (10) step(1, 1, 1, 0, 32'h0);
    if (issued.size() < 2) begin
      chk("wrap_issue_count", issued.size(), 32'd2);
    end else begin
      chk("wrap_first_addr", issued[0], 32'hFFFF_FFFC);
      chk("wrap_next_addr", issued[1], 32'h0000_0000);
    end

    // reset mid-burst with requests outstanding
    repeat (3) step(1, 1, 0, 0, 32'h0);
    chk("pre_reset_outstanding", infl_pc.size(), 32'd2);
    @(negedge clk); #2;
    rst_n = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; m_run = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1, 0, 32'h0);
      if (s_iv && !seen) begin
        seen = 1'b1;
        chk("post_reset_opcode", {25'b0, s_op}, {25'b0, OPC_BRANCH});
        chk("post_reset_id_pc", s_pc, 32'h0);
      end
    end
    chk("post_reset_delivered", {31'b0, seen}, 32'h1);
    if (issued.size() > 0) chk("post_reset_first_addr", issued[0], 32'h0);
    else chk("post_reset_issue_count", issued.size(), 32'd1);

    // random traffic against the reference model
    prev_redir = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      idr = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 3) != 0);
      go  = ($urandom_range(0, 4) < 3);
      rd  = !prev_redir && ($urandom_range(0, 24) == 0);
      step(idr, rdy, go, rd, $urandom());
      prev_redir = rd;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
